rle_pixel_decoder: RTL
======================

RLE_PIXEL_DECODER -- requirements
Module: rle_pixel_decoder

Interface
REQ-001 SHALL have parameter LEN_W, default 9: width of the run-length field.
REQ-002 SHALL have parameter COLOUR_W, default 9: colour width, 3 bits each for R, G, B.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-high reset (the port keeps the codebase name; polarity is high).
REQ-005 SHALL have port data_in, input, 20: instruction at the head of the buffer chain, as [19:18] opcode, [17:9] length, [8:0] colour.
REQ-006 SHALL have port data_valid, input, 1: data_in holds a valid word.
REQ-007 SHALL have port get_next, output, 1: one-cycle pulse; the word on data_in is consumed this cycle.
REQ-008 SHALL have ports next_frame, next_line and next_pixel, each input, 1: strobes from the VGA timing unit; next_pixel is high during the active area.
REQ-009 SHALL have port colour_out, output, COLOUR_W: registered pixel colour.
REQ-010 SHALL have port underflow, output, 1: sticky flag for a word needed while data_valid is low.
REQ-011 SHALL have port frame_err, output, 1: one-cycle pulse when next_frame arrives outside WAIT_FRAME.

Function
REQ-012 SHALL decode opcodes: 00 RUN (colour for length+1 pixels, 1..512); 01 EOL (fill colour until next_line); 10 EOF (black until next_frame); 11 NOP (consumed, no pixels).
REQ-013 SHALL use FSM states IDLE, FETCH, RUN, WAIT_LINE and WAIT_FRAME.
REQ-014 SHALL on get_next latch data_in into opcode/run_cnt/colour registers in the same cycle; the upstream chain presents the next word from the following cycle.
REQ-015 SHALL go IDLE->FETCH on next_frame; FETCH with data_valid -> consume word, go to RUN, WAIT_LINE or WAIT_FRAME by opcode, or stay in FETCH on NOP.
REQ-016 SHALL in RUN, per next_pixel cycle: colour_out <= colour next cycle (latency 1), run_cnt decrements.
REQ-017 SHALL on the last run pixel (run_cnt==0 with next_pixel) assert get_next in that cycle if data_valid, giving back-to-back runs with no pixel gap.
REQ-018 SHALL in the REQ-017 case with data_valid low go to FETCH, set underflow, and output 0 for each pixel until a word arrives.
REQ-019 SHALL let runs span lines: next_line in RUN does not alter run_cnt.
REQ-020 SHALL in WAIT_LINE output the EOL colour per next_pixel; next_line -> FETCH.
REQ-021 SHALL in WAIT_FRAME output 0; next_frame -> FETCH with no frame_err.
REQ-022 SHALL on next_frame in RUN, FETCH or WAIT_LINE pulse frame_err, drop the current run, and go to FETCH (resync to the stream head).
REQ-023 SHALL let next_frame take priority over next_line and next_pixel in the same cycle; next_line takes priority over next_pixel.
REQ-024 SHALL drive colour_out to 0 on any cycle after next_pixel was low (blanking).
REQ-025 SHALL assert get_next at most once per cycle and never while data_valid is low.

Reset
REQ-026 SHALL, with rst_n high at a clock edge, set state=IDLE, colour_out=0, get_next=0, underflow=0, frame_err=0, run_cnt=0 and colour register=0.
REQ-027 SHALL abandon any in-flight run on reset without asserting get_next.
REQ-028 SHALL clear underflow only by reset.

Configuration
REQ-029 SHALL, with RLE_UNDERFLOW_CNT_EN defined, add output underflow_cnt[7:0], a saturating (at 255) count of pixel cycles output as underflow black, reset to 0.
REQ-030 SHALL, without RLE_UNDERFLOW_CNT_EN, omit the port and counter; all other behaviour is identical.

Verification
REQ-031 SHALL test: reset, next_frame, word RUN len=3 col=0x1C0 with next_pixel held -> 4 pixels of 0x1C0 one cycle after, then get_next on the 4th pixel.
REQ-032 SHALL test: back-to-back RUN len=0 col=0x007 then RUN len=1 col=0x038 -> colour_out 0x007, 0x038, 0x038 with no gap, one get_next per word.
REQ-033 SHALL test: EOL col=0x049 mid-line -> 0x049 to end of line; next_line -> next word fetched.
REQ-034 SHALL test: data_valid low at run end -> underflow=1, colour_out=0 (underflow_cnt increments when enabled); data_valid high -> resumes.
REQ-035 SHALL test: next_frame during RUN with run_cnt=100 -> frame_err pulse, new word consumed; next_frame in WAIT_FRAME -> no frame_err.
REQ-036 SHALL test: rst_n high mid-RUN -> all outputs 0 next cycle, state IDLE, no get_next.

Source files
------------

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder feeding a VGA timing unit.
// Consumes 20-bit instructions {opcode[1:0], length[8:0], colour[8:0]} from
// an upstream buffer chain and turns them into one registered colour per
// active pixel. The reset input rst_n is synchronous and active-HIGH.
// Optional feature: define RLE_UNDERFLOW_CNT_EN to add underflow_cnt[7:0],
// a saturating count of pixels blanked because no word was available.
module rle_pixel_decoder #(
  parameter int LEN_W    = 9,
  parameter int COLOUR_W = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LEN_W+COLOUR_W+1:0]   data_in,
  input  logic                        data_valid,
  output logic                        get_next,
  input  logic                        next_frame,
  input  logic                        next_line,
  input  logic                        next_pixel,
  output logic [COLOUR_W-1:0]         colour_out,
  output logic                        underflow,
`ifdef RLE_UNDERFLOW_CNT_EN
  output logic [7:0]                  underflow_cnt,
`endif
  output logic                        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RUN, S_WAIT_LINE, S_WAIT_FRAME
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN = 2'b00, OP_EOL = 2'b01, OP_EOF = 2'b10, OP_NOP = 2'b11
  } opcode_t;

  state_t                r_state;
  state_t                w_state_nxt;
  state_t                w_word_state;
  opcode_t               w_opcode;
  logic [LEN_W-1:0]      r_run_cnt;
  logic [COLOUR_W-1:0]   r_colour;
  logic [COLOUR_W-1:0]   r_colour_out;
  logic [COLOUR_W-1:0]   w_colour_nxt;
  logic                  r_underflow;
  logic                  r_frame_err;
  logic                  w_load;
  logic                  w_run_dec;
  logic                  w_frame_err_nxt;
  logic                  w_underflow_set;

  assign w_opcode = opcode_t'(data_in[LEN_W+COLOUR_W +: 2]);

  // Destination state for the word currently on data_in.
  always_comb begin
    case (w_opcode)
      OP_RUN:  w_word_state = S_RUN;
      OP_EOL:  w_word_state = S_WAIT_LINE;
      OP_EOF:  w_word_state = S_WAIT_FRAME;
      default: w_word_state = S_FETCH;
    endcase
  end

  // Next-state, word consumption and next pixel value; next_frame beats
  // next_line, which beats next_pixel.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_run_dec       = 1'b0;
    w_colour_nxt    = '0;
    w_frame_err_nxt = 1'b0;
    w_underflow_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (next_frame) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (next_frame) begin
          w_frame_err_nxt = 1'b1;
        end else if (data_valid) begin
          w_load      = 1'b1;
          w_state_nxt = w_word_state;
        end else if (next_pixel && !next_line) begin
          w_underflow_set = 1'b1;
        end
      end
      S_RUN: begin
        if (next_frame) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = S_FETCH;
        end else if (next_pixel && !next_line) begin
          w_colour_nxt = r_colour;
          if (r_run_cnt == '0) begin
            if (data_valid) begin
              w_load      = 1'b1;
              w_state_nxt = w_word_state;
            end else begin
              w_underflow_set = 1'b1;
              w_state_nxt     = S_FETCH;
            end
          end else begin
            w_run_dec = 1'b1;
          end
        end
      end
      S_WAIT_LINE: begin
        if (next_frame) begin
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = S_FETCH;
        end else if (next_line) begin
          w_state_nxt = S_FETCH;
        end else if (next_pixel) begin
          w_colour_nxt = r_colour;
        end
      end
      S_WAIT_FRAME: begin
        if (next_frame) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A word is never taken during reset, so an in-flight run is dropped cleanly.
  assign get_next = w_load & ~rst_n;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Instruction registers: load on consumption, count down per run pixel.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_run_cnt <= '0;
      r_colour  <= '0;
    end else if (w_load) begin
      r_run_cnt <= data_in[COLOUR_W +: LEN_W];
      r_colour  <= data_in[COLOUR_W-1:0];
    end else if (w_run_dec) begin
      r_run_cnt <= r_run_cnt - 1'b1;
    end
  end

  // Registered outputs; underflow is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_colour_out <= '0;
      r_frame_err  <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_colour_out <= w_colour_nxt;
      r_frame_err  <= w_frame_err_nxt;
      if (w_underflow_set) r_underflow <= 1'b1;
    end
  end

  assign colour_out = r_colour_out;
  assign frame_err  = r_frame_err;
  assign underflow  = r_underflow;

`ifdef RLE_UNDERFLOW_CNT_EN
  logic [7:0] r_underflow_cnt;
  logic       w_black_pixel;

  // A pixel is blanked for underflow when FETCH has no word to give it.
  assign w_black_pixel = (r_state == S_FETCH) && !next_frame && !data_valid &&
                         !next_line && next_pixel;

  // Saturating count of underflow-blanked pixels.
  always_ff @(posedge clk) begin
    if (rst_n)                                   r_underflow_cnt <= '0;
    else if (w_black_pixel && r_underflow_cnt != 8'hFF) r_underflow_cnt <= r_underflow_cnt + 8'd1;
  end

  assign underflow_cnt = r_underflow_cnt;
`endif

endmodule
